divider_cmd_master: RTL and testbench
=====================================

// Module: divider_cmd_master
// PURPOSE
//  Host-side initiator for the divider mode controller. Packs a (mode, numerator, denominator) request into
//  the 144-bit command word and pulses `write`. It then collects the three-phase 144-bit result word
//  (`write_in`/`write_out`), checks the 0x0A/0x0B tags and returns quotient/remainder on a valid/ready port.
//  Exactly one divide is outstanding at a time.
// PARAMETERS
//  TIMEOUT  default 255  max WAIT cycles after the write pulse before aborting with err=2'b11 (1..65535)
// PORTS
//  divider_clk  in   1    single clock, all logic on posedge
//  reset_n      in   1    asynchronous, active-low reset
//  req_valid    in   1    request present
//  req_ready    out  1    request accepted when req_valid & req_ready
//  req_mode     in   8    1..5 select operand widths; other values invalid
//  req_num      in   64   numerator
//  req_den      in   64   denominator
//  write        out  1    one-cycle command strobe to the controller
//  out_data     out  144  command word {8'h00, mode[7:0], num[63:0], den[63:0]}
//  write_in     in   1    result strobe from the controller (high 3 cycles per result)
//  write_out    in   144  result word
//  resp_valid   out  1    response present; held until accepted
//  resp_ready   in   1    response accepted when resp_valid & resp_ready
//  resp_q       out  64   quotient (o_x), write_out[135:72]
//  resp_r       out  64   remainder (o_y), write_out[63:0]
//  resp_err     out  2    00 ok, 01 bad mode, 10 tag mismatch, 11 timeout
// BEHAVIOUR
//  Reset: all outputs 0, except req_ready=1 one cycle after release (state IDLE). Timeout counter = 0.
//  Reset mid-operation aborts silently; no response is produced for the aborted request.
//  States:
//   IDLE  req_ready=1. On accept:
//         - mode in 1..5: latch the packed word, go to ISSUE.
//         - else: go to RESP with err=01, q=r=0, no write pulse.
//   ISSUE write=1 for exactly one cycle (the cycle after accept), out_data valid. Go to WAIT.
//         out_data stays held until the next accept.
//   WAIT  Count cycles. Detect result on a cycle where write_in==0 and write_in was 1 the previous cycle
//         (falling edge). By then all 144 bits are stable: [143:96] land first, [95:48] second, [47:0] third.
//         On detect: latch q and r, go to RESP.
//         - err=10 if write_out[143:136]!=8'h0A or write_out[71:64]!=8'h0B; q/r are still latched.
//         If the counter reaches TIMEOUT before detect: go to RESP with err=11, q=r=0.
//   RESP  resp_valid=1; resp_q/resp_r/resp_err stable until resp_ready. On handshake: clear resp_valid, go to IDLE.
//  Operand packing (unused upper bits zeroed):
//   mode n=1..4: den field = den[8n-1:0] at out_data[8n-1:0]; num field = num[8n+7:0] at out_data[72+8n-1:64].
//   mode 5: full 64/64.
//   out_data[143:136] is always 0.
//  Latency: accept -> write is 1 cycle; result falling edge -> resp_valid is 1 cycle.
//  write_in edges outside WAIT (IDLE/ISSUE/RESP) are ignored; the previous-cycle flag still tracks them.
//  A falling edge in the same cycle as timeout expiry takes the result (detect wins).
//  Zero denominator is passed through unchecked; the result is whatever the divider returns.
//  req_ready=0 in ISSUE/WAIT/RESP, so back-to-back requests are serialised.
// TESTING
//  1. mode5 num=100 den=7; model controller returns x=14 y=2 using the 3-phase pattern
//     -> out_data={8'h00,8'h05,64'd100,64'd7}, write high exactly 1 cycle; resp q=14 r=2 err=00.
//  2. mode1 num=64'hFFFF_FFFF_FFFF_1234 den=64'hFFFF_FFFF_FFFF_FFAB
//     -> out_data[127:64]=64'h1234, out_data[63:0]=64'hAB.
//  3. mode 8'h07 -> write never pulses; resp_valid within 2 cycles of accept, err=01, q=r=0.
//  4. model drives 8'h0C in place of 8'h0A -> err=10, q/r still as driven.
//  5. no result with TIMEOUT=255 -> err=11 exactly 255 cycles after ISSUE; then IDLE and req_ready=1.
//  6. resp_ready low 10 cycles -> resp fields stable.
//     reset_n pulsed in WAIT -> outputs 0; a later write_in falling edge produces no response.

Source files
------------

// File: rtl/divider_cmd_master.sv
//------------------------------------------------------------------------------
// Module   : divider_cmd_master
// Brief    : Packs divide requests into command words and collects tagged results.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module divider_cmd_master #(
  parameter int TIMEOUT = 255
) (
  input  logic         divider_clk,
  input  logic         reset_n,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [7:0]   req_mode,
  input  logic [63:0]  req_num,
  input  logic [63:0]  req_den,
  output logic         write,
  output logic [143:0] out_data,
  input  logic         write_in,
  input  logic [143:0] write_out,
  output logic         resp_valid,
  input  logic         resp_ready,
  output logic [63:0]  resp_q,
  output logic [63:0]  resp_r,
  output logic [1:0]   resp_err
);

  // Counter runs from the write cycle, so the abort lands TIMEOUT cycles after it.
  localparam logic [15:0] c_TO_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic           r_alive;
  logic           r_win_d;
  logic [15:0]    r_cnt;
  logic [143:0]   r_cmd;
  logic [63:0]    r_q;
  logic [63:0]    r_r;
  logic [1:0]     r_err;

  logic           w_accept;
  logic           w_mode_ok;
  logic           w_fall;
  logic           w_tag_ok;
  logic [63:0]    w_num_p;
  logic [63:0]    w_den_p;
  logic           w_load_cmd;
  logic           w_load_resp;
  logic [63:0]    w_q_nxt;
  logic [63:0]    w_r_nxt;
  logic [1:0]     w_err_nxt;

  assign req_ready  = r_alive & (r_state == S_IDLE);
  assign write      = (r_state == S_ISSUE);
  assign resp_valid = (r_state == S_RESP);
  assign out_data   = r_cmd;
  assign resp_q     = r_q;
  assign resp_r     = r_r;
  assign resp_err   = r_err;

  assign w_accept  = req_valid & req_ready;
  assign w_mode_ok = (req_mode >= 8'd1) && (req_mode <= 8'd5);
  assign w_fall    = r_win_d & ~write_in;
  assign w_tag_ok  = (write_out[143:136] == 8'h0A) && (write_out[71:64] == 8'h0B);

  // Numerator field is one byte wider than the denominator for the narrow modes.
  always_comb begin
    w_num_p = req_num;
    w_den_p = req_den;
    case (req_mode)
      8'd1: begin w_num_p = {48'd0, req_num[15:0]}; w_den_p = {56'd0, req_den[7:0]};  end
      8'd2: begin w_num_p = {40'd0, req_num[23:0]}; w_den_p = {48'd0, req_den[15:0]}; end
      8'd3: begin w_num_p = {32'd0, req_num[31:0]}; w_den_p = {40'd0, req_den[23:0]}; end
      8'd4: begin w_num_p = {24'd0, req_num[39:0]}; w_den_p = {32'd0, req_den[31:0]}; end
      default: ;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load_cmd  = 1'b0;
    w_load_resp = 1'b0;
    w_q_nxt     = 64'd0;
    w_r_nxt     = 64'd0;
    w_err_nxt   = 2'b00;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_mode_ok) begin
            w_load_cmd  = 1'b1;
            w_state_nxt = S_ISSUE;
          end else begin
            w_load_resp = 1'b1;
            w_err_nxt   = 2'b01;
            w_state_nxt = S_RESP;
          end
        end
      end
      S_ISSUE: w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (w_fall) begin
          w_load_resp = 1'b1;
          w_q_nxt     = write_out[135:72];
          w_r_nxt     = write_out[63:0];
          w_err_nxt   = w_tag_ok ? 2'b00 : 2'b10;
          w_state_nxt = S_RESP;
        end else if (r_cnt >= c_TO_LAST) begin
          w_load_resp = 1'b1;
          w_err_nxt   = 2'b11;
          w_state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        if (resp_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge divider_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge divider_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_alive <= 1'b0;
      r_win_d <= 1'b0;
      r_cnt   <= 16'd0;
      r_cmd   <= 144'd0;
      r_q     <= 64'd0;
      r_r     <= 64'd0;
      r_err   <= 2'b00;
    end else begin
      r_alive <= 1'b1;
      r_win_d <= write_in;
      if (w_accept) begin
        r_cnt <= 16'd0;
      end else if ((r_state == S_ISSUE) || (r_state == S_WAIT)) begin
        r_cnt <= r_cnt + 16'd1;
      end
      if (w_load_cmd) begin
        r_cmd <= {8'h00, req_mode, w_num_p, w_den_p};
      end
      if (w_load_resp) begin
        r_q   <= w_q_nxt;
        r_r   <= w_r_nxt;
        r_err <= w_err_nxt;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_divider_cmd_master.sv
//------------------------------------------------------------------------------
// Module   : tb_divider_cmd_master
// Brief    : Directed plus randomized bench with a behavioural divider controller model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_divider_cmd_master;

  localparam int TO = 255;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [7:0]   req_mode = 8'd0;
  logic [63:0]  req_num = 64'd0;
  logic [63:0]  req_den = 64'd0;
  logic         write;
  logic [143:0] out_data;
  logic         write_in = 1'b0;
  logic [143:0] write_out = 144'd0;
  logic         resp_valid;
  logic         resp_ready = 1'b0;
  logic [63:0]  resp_q;
  logic [63:0]  resp_r;
  logic [1:0]   resp_err;

  int checks = 0;
  int errors = 0;

  divider_cmd_master #(.TIMEOUT(TO)) dut (
    .divider_clk(clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_mode   (req_mode),
    .req_num    (req_num),
    .req_den    (req_den),
    .write      (write),
    .out_data   (out_data),
    .write_in   (write_in),
    .write_out  (write_out),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_q     (resp_q),
    .resp_r     (resp_r),
    .resp_err   (resp_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [143:0] got, input logic [143:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference command word: keep the low bits of each operand by modular arithmetic.
  function automatic logic [143:0] ref_cmd(input logic [7:0] mode, input logic [63:0] num,
                                           input logic [63:0] den);
    int nb;
    int db;
    logic [127:0] pn;
    logic [127:0] pd;
    if (mode == 8'd5) begin
      nb = 64;
      db = 64;
    end else begin
      db = 8 * int'(mode);
      nb = db + 8;
    end
    pn = {64'd0, num} % (128'd1 << nb);
    pd = {64'd0, den} % (128'd1 << db);
    return {8'h00, mode, pn[63:0], pd[63:0]};
  endfunction

  task automatic expect_zero_outputs(input string tag);
    check({tag, ".write"}, write, 0);
    check({tag, ".out_data"}, out_data, 0);
    check({tag, ".req_ready"}, req_ready, 0);
    check({tag, ".resp_valid"}, resp_valid, 0);
    check({tag, ".resp_q"}, resp_q, 0);
    check({tag, ".resp_r"}, resp_r, 0);
    check({tag, ".resp_err"}, resp_err, 0);
  endtask

  task automatic finish_resp(input string tag);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    check({tag, ".resp_cleared"}, resp_valid, 0);
    check({tag, ".ready_again"}, req_ready, 1);
  endtask

  // One full divide; the controller model answers with tag_a in the high tag slot.
  task automatic do_txn(input string tag, input logic [7:0] mode, input logic [63:0] num,
                        input logic [63:0] den, input logic [7:0] tag_a, input int hold);
    logic [143:0] cmd;
    logic [143:0] res;
    logic [63:0]  eq;
    logic [63:0]  er;
    logic [1:0]   ee;
    cmd = ref_cmd(mode, num, den);
    eq  = cmd[127:64] / cmd[63:0];
    er  = cmd[127:64] % cmd[63:0];
    ee  = (tag_a == 8'h0A) ? 2'b00 : 2'b10;
    res = {tag_a, eq, 8'h0B, er};
    check({tag, ".req_ready"}, req_ready, 1);
    req_mode = mode; req_num = num; req_den = den; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    check({tag, ".write_hi"}, write, 1);
    check({tag, ".out_data"}, out_data, cmd);
    tick();
    check({tag, ".write_lo"}, write, 0);
    repeat ($urandom_range(0, 4)) tick();
    write_out = {res[143:96], 96'd0};
    write_in  = 1'b1;
    tick();
    write_out = {res[143:48], 48'd0};
    tick();
    write_out = res;
    tick();
    write_in = 1'b0;
    check({tag, ".no_early_resp"}, resp_valid, 0);
    tick();
    check({tag, ".resp_valid"}, resp_valid, 1);
    for (int i = 0; i <= hold; i++) begin
      check({tag, ".q"}, resp_q, eq);
      check({tag, ".r"}, resp_r, er);
      check({tag, ".err"}, resp_err, ee);
      if (i < hold) begin
        tick();
        check({tag, ".held_valid"}, resp_valid, 1);
      end
    end
    check({tag, ".out_data_held"}, out_data, cmd);
    finish_resp(tag);
  endtask

  initial begin
    int n;
    logic [7:0] m;

    // Reset state
    tick();
    expect_zero_outputs("reset");
    reset_n = 1'b1;
    tick();
    check("reset.ready_after_release", req_ready, 1);

    // A result strobe while idle is ignored
    write_in = 1'b1;
    repeat (3) tick();
    write_in = 1'b0;
    repeat (2) tick();
    check("idle_edge.no_resp", resp_valid, 0);

    // Directed cases
    do_txn("t1_mode5", 8'd5, 64'd100, 64'd7, 8'h0A, 10);
    do_txn("t2_mode1", 8'd1, 64'hFFFF_FFFF_FFFF_1234, 64'hFFFF_FFFF_FFFF_FFAB, 8'h0A, 0);
    do_txn("t4_badtag", 8'd3, 64'd123456, 64'd77, 8'h0C, 2);

    // Invalid mode: no write, immediate error response
    req_mode = 8'h07; req_num = 64'd9; req_den = 64'd3; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    check("t3_badmode.write", write, 0);
    check("t3_badmode.resp_valid", resp_valid, 1);
    check("t3_badmode.err", resp_err, 2'b01);
    check("t3_badmode.q", resp_q, 0);
    check("t3_badmode.r", resp_r, 0);
    finish_resp("t3_badmode");

    // Timeout: no result ever arrives
    req_mode = 8'd2; req_num = 64'd50; req_den = 64'd5; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    check("t5_timeout.write", write, 1);
    n = 0;
    do begin
      tick();
      n++;
    end while (!resp_valid && n < TO + 20);
    check("t5_timeout.latency", 144'(n), 144'(TO));
    check("t5_timeout.err", resp_err, 2'b11);
    check("t5_timeout.q", resp_q, 0);
    check("t5_timeout.r", resp_r, 0);
    finish_resp("t5_timeout");

    // Randomized requests against the reference model
    for (int k = 0; k < 10; k++) begin
      m = 8'($urandom_range(1, 5));
      do_txn("rand", m, {$urandom, $urandom}, {$urandom, $urandom} | 64'd1,
             8'h0A, $urandom_range(0, 3));
    end

    // Reset in WAIT aborts silently
    req_mode = 8'd5; req_num = 64'd1000; req_den = 64'd10; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    reset_n = 1'b0;
    #1;
    expect_zero_outputs("t6_reset_wait");
    tick();
    reset_n = 1'b1;
    write_out = {8'h0A, 64'd100, 8'h0B, 64'd0};
    write_in  = 1'b1;
    repeat (3) tick();
    write_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t6_reset_wait.no_resp", resp_valid, 0);
    end
    check("t6_reset_wait.ready", req_ready, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
